parallel_pe: RTL and testbench

Parameterised multi-lane successor to `serial_pe`. Each accepted beat multiplies `LANES` signed neuron/weight pairs in parallel and reduces the products through an adder tree. The tree sum is accumulated over a `ctl`-delimited sequence of beats, giving one dot-product result per sequence. The block sits between the neuron/weight line buffers (one 512-bit line per beat at default parameters) and the output writeback, in place of the serial PE.

---
 rtl/parallel_pe.sv | 140 ++++++++++++++
 tb/tb_parallel_pe.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_pe.sv
// Multi-lane dot-product engine: LANES parallel signed multiplies, an exact adder tree,
// and a ctl-delimited accumulator with optional saturation and ReLU.
module parallel_pe #(
    parameter int DW    = 16,
    parameter int LANES = 32,
    parameter int ACC_W = 32,
    parameter int SAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LANES*DW-1:0]   neuron,
    input  logic [LANES*DW-1:0]   weight,
    input  logic [1:0]            ctl,
    input  logic                  vld_i,
    input  logic                  relu_en,
    output logic [ACC_W-1:0]      result,
    output logic                  vld_o,
    output logic                  ovf,
    output logic                  err
);
    localparam int PW = 2 * DW;
    localparam int TW = PW + $clog2(LANES);
    localparam int XW = ((ACC_W > TW) ? ACC_W : TW) + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {S_IDLE, S_ACC} state_t;

    state_t state;
    logic   beat_ok;

    // A first/single beat is always taken; middle/last beats only inside an open sequence.
    assign beat_ok = vld_i && (ctl[0] || state == S_ACC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            err   <= 1'b0;
        end else begin
            err <= vld_i && !ctl[0] && state == S_IDLE;
            if (beat_ok)
                state <= ctl[1] ? S_IDLE : S_ACC;
        end
    end

    // Stage 1: lane products
    logic signed [PW-1:0] prod [LANES];
    logic                 s1_vld, s1_first, s1_last, s1_relu;

    // NOTE: datapath registers carry no reset; only the valid/tag flops that qualify them do.
    always_ff @(posedge clk) begin
        if (beat_ok) begin
            for (int k = 0; k < LANES; k++)
                prod[k] <= PW'($signed(neuron[k*DW +: DW])) * PW'($signed(weight[k*DW +: DW]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_relu  <= 1'b0;
        end else begin
            s1_vld   <= beat_ok;
            s1_first <= ctl[0];
            s1_last  <= ctl[1];
            s1_relu  <= relu_en;
        end
    end

    // Stage 2: exact adder tree
    logic signed [TW-1:0] tree_sum, s2_sum;
    logic                 s2_vld, s2_first, s2_last, s2_relu;

    // NOTE: every always_comb variable gets a default before the loop so no latch can form.
    always_comb begin
        tree_sum = '0;
        for (int k = 0; k < LANES; k++)
            tree_sum = tree_sum + {{(TW-PW){prod[k][PW-1]}}, prod[k]};
    end

    always_ff @(posedge clk) begin
        if (s1_vld)
            s2_sum <= tree_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld   <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_relu  <= 1'b0;
        end else begin
            s2_vld   <= s1_vld;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_relu  <= s1_relu;
        end
    end

    // Stage 3: accumulator; the final value is published one edge later
    logic [ACC_W-1:0] acc, acc_new;
    logic [XW-1:0]    acc_base, acc_next;
    logic             fits, ovf_acc, relu_seq, s3_fin;

    always_comb begin
        acc_base = s2_first ? '0 : {{(XW-ACC_W){acc[ACC_W-1]}}, acc};
        acc_next = acc_base + {{(XW-TW){s2_sum[TW-1]}}, s2_sum};
        fits     = acc_next == {{(XW-ACC_W){acc_next[ACC_W-1]}}, acc_next[ACC_W-1:0]};
        if (SAT != 0 && !fits)
            acc_new = acc_next[XW-1] ? ACC_MIN : ACC_MAX;
        else
            acc_new = acc_next[ACC_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            ovf_acc  <= 1'b0;
            relu_seq <= 1'b0;
            s3_fin   <= 1'b0;
            result   <= '0;
            vld_o    <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            s3_fin <= s2_vld && s2_last;
            if (s2_vld) begin
                acc      <= acc_new;
                ovf_acc  <= (s2_first ? 1'b0 : ovf_acc) | !fits;
                relu_seq <= s2_first ? s2_relu : relu_seq;
            end
            vld_o <= s3_fin;
            if (s3_fin) begin
                result <= (relu_seq && acc[ACC_W-1]) ? '0 : acc;
                ovf    <= ovf_acc;
            end
        end
    end
endmodule

// File: tb/tb_parallel_pe.sv
// Directed bench for parallel_pe: a saturating and a wrapping instance share the stimulus.
module tb_parallel_pe;
    localparam int DW = 16;
    localparam int LANES = 32;
    localparam int ACC_W = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic [LANES*DW-1:0] neuron, weight;
    logic [1:0] ctl;
    logic vld_i, relu_en;
    logic [ACC_W-1:0] result_s, result_w;
    logic vld_o_s, vld_o_w, ovf_s, ovf_w, err_s, err_w;

    always #5 clk = ~clk;

    parallel_pe #(.DW(DW), .LANES(LANES), .ACC_W(ACC_W), .SAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .neuron(neuron), .weight(weight), .ctl(ctl),
        .vld_i(vld_i), .relu_en(relu_en), .result(result_s), .vld_o(vld_o_s),
        .ovf(ovf_s), .err(err_s));

    parallel_pe #(.DW(DW), .LANES(LANES), .ACC_W(ACC_W), .SAT(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .neuron(neuron), .weight(weight), .ctl(ctl),
        .vld_i(vld_i), .relu_en(relu_en), .result(result_w), .vld_o(vld_o_w),
        .ovf(ovf_w), .err(err_w));

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor on the saturating instance
    int vld_cnt = 0;
    int err_cnt = 0;
    logic [ACC_W-1:0] res_q[$];

    always @(negedge clk) begin
        if (vld_o_s === 1'b1) begin
            vld_cnt++;
            res_q.push_back(result_s);
        end
        if (err_s === 1'b1)
            err_cnt++;
    end

    function automatic logic [LANES*DW-1:0] rep(input logic [DW-1:0] v);
        logic [LANES*DW-1:0] r;
        for (int k = 0; k < LANES; k++)
            r[k*DW +: DW] = v;
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge with vld_i low.
    task automatic beat(input logic [1:0] c, input logic [LANES*DW-1:0] n,
                        input logic [LANES*DW-1:0] w, input logic r);
        ctl = c;
        neuron = n;
        weight = w;
        relu_en = r;
        vld_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld_i = 1'b0;
        ctl = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_vld(output int lat);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (vld_o_s === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    function automatic logic [1:0] ctl_for(input int b, input int beats);
        if (beats == 1) return 2'b11;
        if (b == 0) return 2'b01;
        if (b == beats - 1) return 2'b10;
        return 2'b00;
    endfunction

    typedef struct {
        logic [DW-1:0]    n;
        logic [DW-1:0]    w;
        int               beats;
        logic             relu;
        logic [ACC_W-1:0] res_sat;
        logic             ovf_sat;
        logic [ACC_W-1:0] res_wrap;
        logic             ovf_wrap;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat;
        int v0, e0, q0;
        logic [LANES*DW-1:0] nd[16];
        logic [LANES*DW-1:0] wd[16];
        longint exp_sum[4];

        vecs[0] = '{16'sd1,      16'sd2,      1,  1'b0, 32'h0000_0040, 1'b0, 32'h0000_0040, 1'b0};
        vecs[1] = '{16'sd3,      -16'sd1,     16, 1'b0, 32'hFFFF_FA00, 1'b0, 32'hFFFF_FA00, 1'b0};
        vecs[2] = '{16'sd3,      -16'sd1,     16, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        vecs[3] = '{16'h8000,    16'h8000,    3,  1'b0, 32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b1};
        vecs[4] = '{-16'sd5,     -16'sd9,     5,  1'b1, 32'h0000_1C20, 1'b0, 32'h0000_1C20, 1'b0};
        vecs[5] = '{16'h8000,    16'h7FFF,    1,  1'b0, 32'h8000_0000, 1'b1, 32'h0010_0000, 1'b1};

        rst_n = 1'b0;
        vld_i = 1'b0;
        ctl = 2'b00;
        relu_en = 1'b0;
        neuron = '0;
        weight = '0;
        idle(3);
        check("reset result", result_s, 0);
        check("reset vld_o", vld_o_s, 0);
        check("reset ovf", ovf_s, 0);
        check("reset err", err_s, 0);
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 6; i++) begin
            for (int b = 0; b < vecs[i].beats; b++)
                beat(ctl_for(b, vecs[i].beats), rep(vecs[i].n), rep(vecs[i].w), vecs[i].relu);
            wait_vld(lat);
            check($sformatf("vec%0d latency", i), lat, 3);
            check($sformatf("vec%0d sat result", i), result_s, vecs[i].res_sat);
            check($sformatf("vec%0d sat ovf", i), ovf_s, vecs[i].ovf_sat);
            check($sformatf("vec%0d wrap vld_o", i), vld_o_w, 1);
            check($sformatf("vec%0d wrap result", i), result_w, vecs[i].res_wrap);
            check($sformatf("vec%0d wrap ovf", i), ovf_w, vecs[i].ovf_wrap);
            idle(1);
            check($sformatf("vec%0d pulse width", i), vld_o_s, 0);
            idle(2);
        end

        // Four back-to-back sequences with gaps only inside each sequence
        for (int s = 0; s < 4; s++) begin
            exp_sum[s] = 0;
            for (int b = 0; b < 4; b++) begin
                for (int k = 0; k < LANES; k++) begin
                    int a, c;
                    a = int'($urandom_range(0, 200)) - 100;
                    c = int'($urandom_range(0, 200)) - 100;
                    nd[s*4+b][k*DW +: DW] = DW'(a);
                    wd[s*4+b][k*DW +: DW] = DW'(c);
                    exp_sum[s] += longint'(a) * longint'(c);
                end
            end
        end
        v0 = vld_cnt;
        q0 = res_q.size();
        for (int s = 0; s < 4; s++) begin
            for (int b = 0; b < 4; b++) begin
                if (b > 0)
                    idle(int'($urandom_range(0, 2)));
                beat(ctl_for(b, 4), nd[s*4+b], wd[s*4+b], 1'b0);
            end
        end
        idle(8);
        check("b2b vld count", vld_cnt - v0, 4);
        for (int s = 0; s < 4; s++) begin
            logic [63:0] es;
            es = 64'(exp_sum[s]);
            if (res_q.size() > q0 + s)
                check($sformatf("b2b result%0d", s), res_q[q0+s], es[ACC_W-1:0]);
            else
                check($sformatf("b2b result%0d present", s), 0, 1);
        end

        // Protocol errors in IDLE
        v0 = vld_cnt;
        beat(2'b00, rep(16'sd1), rep(16'sd1), 1'b0);
        check("err on 00 in idle", err_s, 1);
        idle(1);
        check("err single cycle", err_s, 0);
        beat(2'b10, rep(16'sd1), rep(16'sd1), 1'b0);
        check("err on 10 in idle", err_s, 1);
        idle(6);
        check("no vld_o on dropped beats", vld_cnt - v0, 0);

        // Restart via 01 discards the open sequence silently
        v0 = vld_cnt;
        e0 = err_cnt;
        beat(2'b01, rep(16'sd1), rep(16'sd1), 1'b0);
        beat(2'b00, rep(16'sd1), rep(16'sd1), 1'b0);
        beat(2'b01, rep(16'sd1), rep(16'sd1), 1'b0);
        beat(2'b10, rep(16'sd1), rep(16'sd1), 1'b0);
        idle(8);
        check("restart 01 vld count", vld_cnt - v0, 1);
        check("restart 01 result", res_q[$], 64);
        check("restart 01 no err", err_cnt - e0, 0);

        // Restart via 11 discards and emits a single-beat result
        v0 = vld_cnt;
        beat(2'b01, rep(16'sd5), rep(16'sd5), 1'b0);
        beat(2'b00, rep(16'sd5), rep(16'sd5), 1'b0);
        beat(2'b11, rep(16'sd1), rep(16'sd2), 1'b0);
        idle(8);
        check("restart 11 vld count", vld_cnt - v0, 1);
        check("restart 11 result", res_q[$], 64);

        // Reset mid-sequence
        for (int b = 0; b < 5; b++)
            beat(ctl_for(b, 16), rep(16'sd3), rep(-16'sd1), 1'b0);
        rst_n = 1'b0;
        #1;
        check("midreset result", result_s, 0);
        check("midreset vld_o", vld_o_s, 0);
        check("midreset ovf", ovf_s, 0);
        check("midreset err", err_s, 0);
        idle(2);
        rst_n = 1'b1;
        v0 = vld_cnt;
        idle(6);
        check("midreset no vld_o", vld_cnt - v0, 0);
        beat(2'b11, rep(16'sd1), rep(16'sd2), 1'b0);
        wait_vld(lat);
        check("post reset latency", lat, 3);
        check("post reset result", result_s, 64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
